dmem_access_unit: RTL and testbench
===================================

# dmem_access_unit

MEM-stage data-memory access controller for the 5-stage RV32 pipeline, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns the EX/MEM load/store request into a req/ack transaction on a multi-cycle data-memory port, and stalls the pipeline while the transaction is outstanding. It also performs byte/halfword lane alignment with sign or zero extension, and produces the load data consumed by MEM/WB.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of the data-memory byte address.

Ports:
- clk_i  input  1  single clock, all state updates on posedge.
- rst_i  input  1  reset: asynchronous, active-low.
- MemRead_in  input  1  load request from EX/MEM.
- MemWrite_in  input  1  store request from EX/MEM; has priority if both are high.
- funct3_in  input  3  access size: 000 b, 001 h, 010 w, 100 bu, 101 hu; other codes act as w.
- addr_in  input  ADDR_WIDTH  byte address (ALU result).
- wdata_in  input  32  store data (rs2).
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  1 = write.
- mem_addr_o  output  ADDR_WIDTH  word-aligned address, addr_in with [1:0] forced to 0.
- mem_be_o  output  4  byte enables.
- mem_wdata_o  output  32  lane-replicated store data.
- mem_ack_i  input  1  transaction complete; mem_rdata_i is valid in the same cycle.
- mem_rdata_i  input  32  raw read word.
- stall_o  output  1  freeze PC, IF/ID, ID/EX and EX/MEM; bubble into MEM/WB.
- read_addr_data_o  output  32  aligned/extended load data, feeds MEM/WB.
- misaligned_o  output  1  access suppressed due to misalignment.

## Operation
- FSM states: IDLE, REQ, DONE.
  - IDLE -> REQ on a valid aligned access (MemRead_in | MemWrite_in).
  - REQ -> DONE on mem_ack_i.
  - DONE -> IDLE unconditionally.
- DONE never re-triggers, even though the EX/MEM inputs still show the same instruction during that cycle.
- Misalignment rules:
  - w with addr[1:0] != 0 is misaligned.
  - h, hu or sh with addr[0] = 1 is misaligned.
  - A misaligned access raises misaligned_o combinationally in IDLE, issues no memory request, produces no stall and stays in IDLE.
- Request registers: addr, we, be and wdata are captured on the IDLE->REQ transition and held stable in REQ.
- Store lanes:
  - sb: wdata = {4{wdata[7:0]}}, be = 0001 << addr[1:0].
  - sh: wdata = {2{wdata[15:0]}}, be = addr[1] ? 1100 : 0011.
  - sw: be = 1111.
- Load lanes:
  - Loads drive be = 1111.
  - On ack, select the byte or halfword by the captured addr[1:0], sign-extend (b, h) or zero-extend (bu, hu), and register the result into read_addr_data_o.
- read_addr_data_o changes only on a load ack. Stores and misaligned accesses leave it unchanged.
- mem_ack_i outside REQ is ignored.
- Reset values: state IDLE; mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_be_o 0, mem_wdata_o 0, read_addr_data_o 0.
- Reset mid-transaction abandons the access. The memory must tolerate mem_req_o dropping without ack.

## Timing
- stall_o = (IDLE & valid aligned access) | REQ. It is combinational, so the pipeline freezes in the same cycle the access appears.
- mem_req_o = registered (state == REQ). It is held high until the cycle in which mem_ack_i is sampled high.
- Minimum latency, with ack in the first REQ cycle:
  - Cycle 0: IDLE, stall_o high.
  - Cycle 1: REQ, ack arrives.
  - Cycle 2: DONE, stall_o low, read_addr_data_o valid. MEM/WB captures it at the end of cycle 2.
- General case: the access occupies 2 + N stall cycles, where N is the number of extra REQ cycles before ack.
- Back-to-back accesses: the next access is seen in the cycle after DONE.
- misaligned_o is valid only in IDLE and is 0 in REQ and DONE.

## Structure
- cpu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The FSM state enum.
  - The be-pattern constants.
- load_align is a natural sub-module. It is combinational: inputs are the raw word, addr[1:0] and funct3; output is the extended 32-bit data. The controller instantiates it once.
- The controller holds the FSM, the request-capture registers and the store-lane logic.

## Test plan
- lw, addr 0x100, ack after 3 REQ cycles -> stall_o high for 4 cycles; mem_req_o high for 3; read_addr_data_o = 0xDEADBEEF in DONE.
- lb, addr 0x103, rdata 0x80112233 -> 0xFFFFFF80. lbu at the same address -> 0x00000080. lhu, addr 0x102 -> 0x00008011.
- sb, addr 0x101, wdata 0x000000AB -> be 0010, wdata 0xABABABAB, we 1. read_addr_data_o is unchanged.
- lw at 0x102 and sh at 0x101 -> misaligned_o 1, mem_req_o never asserted, stall_o 0.
- rst_i low during REQ -> same-cycle mem_req_o 0, state IDLE, all outputs at reset values. After release, a new lw completes normally.
- Two consecutive loads, each acked in the first REQ cycle -> stall pattern 1,1,0,1,1,0. A spurious mem_ack_i in IDLE has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared funct3 codes, byte-enable patterns and FSM state for the MEM stage
package cpu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] BE_B   = 4'b0001;
  localparam logic [3:0] BE_HLO = 4'b0011;
  localparam logic [3:0] BE_HHI = 4'b1100;
  localparam logic [3:0] BE_W   = 4'b1111;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
  function automatic logic is_byte(input logic [2:0] f);
    return f == F3_B || f == F3_BU;
  endfunction
  function automatic logic is_half(input logic [2:0] f);
    return f == F3_H || f == F3_HU;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/halfword of a read word and sign/zero-extends it
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sx;
  always_comb begin
    byte_v = off_i[1] ? (off_i[0] ? rdata_i[31:24] : rdata_i[23:16])
                      : (off_i[0] ? rdata_i[15:8]  : rdata_i[7:0]);
    half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sx     = !funct3_i[2];
    data_o = is_byte(funct3_i) ? {{24{sx & byte_v[7]}}, byte_v} :
             is_half(funct3_i) ? {{16{sx & half_v[15]}}, half_v} : rdata_i;
  end
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store controller driving a req/ack data-memory port and stalling the pipeline
module dmem_access_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  MemRead_in,
  input  logic                  MemWrite_in,
  input  logic [2:0]            funct3_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [31:0]           wdata_in,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  stall_o,
  output logic [31:0]           read_addr_data_o,
  output logic                  misaligned_o
);
  state_e                state_q;
  logic                  req_q, we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d, rdata_q, ld_data;
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic                  isb, ish, acc, mis, go;
  always_comb begin
    isb          = is_byte(funct3_in);
    ish          = is_half(funct3_in);
    acc          = MemRead_in | MemWrite_in;
    mis          = ish ? addr_in[0] : (!isb && addr_in[1:0] != 2'b00);
    go           = state_q == IDLE && acc && !mis;
    stall_o      = go || state_q == REQ;
    misaligned_o = state_q == IDLE && acc && mis;
    be_d         = !MemWrite_in ? BE_W :
                   isb ? BE_B << addr_in[1:0] :
                   ish ? (addr_in[1] ? BE_HHI : BE_HLO) : BE_W;
    wdata_d      = isb ? {4{wdata_in[7:0]}} : ish ? {2{wdata_in[15:0]}} : wdata_in;
  end
  load_align u_align (
    .rdata_i  (mem_rdata_i),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );
  // DONE always returns to IDLE, so the still-visible EX/MEM request cannot re-trigger
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (go) begin
          state_q <= REQ;
          req_q   <= 1'b1;
          we_q    <= MemWrite_in;
          addr_q  <= {addr_in[ADDR_WIDTH-1:2], 2'b00};
          be_q    <= be_d;
          wdata_q <= wdata_d;
          off_q   <= addr_in[1:0];
          f3_q    <= funct3_in;
        end
        REQ: if (mem_ack_i) begin
          state_q <= DONE;
          req_q   <= 1'b0;
          if (!we_q) rdata_q <= ld_data;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_req_o        = req_q;
  assign mem_we_o         = we_q;
  assign mem_addr_o       = addr_q;
  assign mem_be_o         = be_q;
  assign mem_wdata_o      = wdata_q;
  assign read_addr_data_o = rdata_q;
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed checks of stall/request timing, lane alignment, misalignment and reset
module tb_dmem_access_unit;
  import cpu_pkg::*;
  logic        clk = 1'b0, rst_i = 1'b0;
  logic        rd = 1'b0, wr = 1'b0, ack = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0, wd = '0, rdata = '0;
  logic        mem_req, mem_we, stall, mis;
  logic [31:0] mem_addr, mem_wdata, ld;
  logic [3:0]  mem_be;
  int n_pass = 0, n_chk = 0, ns, nr;
  bit done;

  dmem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .MemRead_in(rd), .MemWrite_in(wr), .funct3_in(f3),
    .addr_in(addr), .wdata_in(wd), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_ack_i(ack), .mem_rdata_i(rdata), .stall_o(stall),
    .read_addr_data_o(ld), .misaligned_o(mis)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Presents one access and acks it on REQ cycle extra+1; returns at DONE (or IDLE if it never stalled)
  task automatic run(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] rw, input int extra);
    @(negedge clk);
    rd = r; wr = w; f3 = f; addr = a; wd = d; rdata = rw; ack = 1'b0;
    ns = 0; nr = 0; done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (stall) ns++;
      if (mem_req) nr++;
      if (!stall) begin done = 1'b1; break; end
      ack = mem_req && (nr == extra + 1);
      @(negedge clk);
    end
    check("terminated", 32'(done), 32'd1);
  endtask

  task automatic clear();
    rd = 1'b0; wr = 1'b0; ack = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_ld", ld, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clk); rst_i = 1'b1;

    run(1, 0, F3_W, 32'h100, 0, 32'hDEADBEEF, 2);
    check("lw_stall_cycles", ns, 4);
    check("lw_req_cycles", nr, 3);
    check("lw_data", ld, 32'hDEADBEEF);
    check("lw_addr", mem_addr, 32'h100);
    check("lw_be", 32'(mem_be), 32'hF);
    check("lw_done_noreq", 32'(mem_req), 32'd0);
    clear();

    run(1, 0, F3_B, 32'h103, 0, 32'h80112233, 0);
    check("lb_data", ld, 32'hFFFFFF80);
    check("lb_stall_cycles", ns, 2);
    clear();
    run(1, 0, F3_BU, 32'h103, 0, 32'h80112233, 0);
    check("lbu_data", ld, 32'h00000080);
    clear();
    run(1, 0, F3_HU, 32'h102, 0, 32'h80112233, 1);
    check("lhu_data", ld, 32'h00008011);
    check("lhu_stall_cycles", ns, 3);
    clear();
    run(1, 0, F3_H, 32'h102, 0, 32'h80112233, 0);
    check("lh_data", ld, 32'hFFFF8011);
    clear();
    run(1, 0, F3_B, 32'h101, 0, 32'h80112233, 0);
    check("lb1_data", ld, 32'h00000022);
    clear();

    run(0, 1, F3_B, 32'h101, 32'h000000AB, 32'h55555555, 0);
    check("sb_be", 32'(mem_be), 32'b0010);
    check("sb_wdata", mem_wdata, 32'hABABABAB);
    check("sb_we", 32'(mem_we), 32'd1);
    check("sb_addr", mem_addr, 32'h100);
    check("sb_ld_kept", ld, 32'h00000022);
    clear();
    run(0, 1, F3_H, 32'h102, 32'h1234CDEF, 32'h55555555, 0);
    check("sh_be", 32'(mem_be), 32'b1100);
    check("sh_wdata", mem_wdata, 32'hCDEFCDEF);
    clear();
    run(0, 1, F3_W, 32'h204, 32'h01020304, 32'h55555555, 0);
    check("sw_be", 32'(mem_be), 32'hF);
    check("sw_wdata", mem_wdata, 32'h01020304);
    check("sw_addr", mem_addr, 32'h204);
    check("sw_ld_kept", ld, 32'h00000022);
    clear();

    run(1, 0, F3_W, 32'h102, 0, 32'h0, 0);
    check("lw_mis_flag", 32'(mis), 32'd1);
    check("lw_mis_stall", ns, 0);
    check("lw_mis_req", nr, 0);
    @(negedge clk); #1;
    check("lw_mis_noreq_later", 32'(mem_req), 32'd0);
    clear();
    run(0, 1, F3_H, 32'h101, 32'hFFFF, 32'h0, 0);
    check("sh_mis_flag", 32'(mis), 32'd1);
    check("sh_mis_stall", ns, 0);
    @(negedge clk); #1;
    check("sh_mis_noreq_later", 32'(mem_req), 32'd0);
    check("sh_mis_ld_kept", ld, 32'h00000022);
    clear();

    @(negedge clk);
    rd = 1'b1; f3 = F3_W; addr = 32'h300;
    @(negedge clk); #1;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    check("req_mis_low", 32'(mis), 32'd0);
    #2 rst_i = 1'b0; #1;
    check("arst_req", 32'(mem_req), 32'd0);
    check("arst_ld", ld, 32'd0);
    check("arst_be", 32'(mem_be), 32'd0);
    check("arst_addr", mem_addr, 32'd0);
    clear();
    @(negedge clk); rst_i = 1'b1;
    run(1, 0, F3_W, 32'h104, 0, 32'hCAFEF00D, 0);
    check("post_rst_lw", ld, 32'hCAFEF00D);
    check("post_rst_stall", ns, 2);
    clear();

    run(1, 0, F3_W, 32'h108, 0, 32'h11111111, 0);
    check("b2b1_stall", ns, 2);
    check("b2b1_done_stall", 32'(stall), 32'd0);
    clear();
    run(1, 0, F3_W, 32'h10C, 0, 32'h22222222, 0);
    check("b2b2_stall", ns, 2);
    check("b2b2_data", ld, 32'h22222222);
    clear();

    @(negedge clk);
    ack = 1'b1; rdata = 32'h99999999;
    @(negedge clk); #1;
    check("spur_ack_req", 32'(mem_req), 32'd0);
    check("spur_ack_stall", 32'(stall), 32'd0);
    check("spur_ack_ld", ld, 32'h22222222);
    clear();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
